// File: rtl/alu_seq16.sv
// alu_seq16: sequences one 16-bit ADD/SUB/INC/DEC through the shared 8-bit alu as two byte passes.
// Optional macro ALU_SEQ16_B2B_EN lets a new request be accepted in the same edge as the response handshake.
module alu_seq16 #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned RES_SIZE  = 16,
  localparam int unsigned WORD_W   = 2 * DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [WORD_W-1:0]    req_a_i,
  input  logic [WORD_W-1:0]    req_b_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [WORD_W-1:0]    resp_data_o,
  output logic                 resp_c_o,
  output logic                 resp_z_o,
  output logic                 resp_flags_we_o,
  output logic [2:0]           alu_op_o,
  output logic                 alu_ext_o,
  output logic                 alu_misc_o,
  output logic [DATA_SIZE-1:0] alu_src_o,
  output logic [DATA_SIZE-1:0] alu_dest_o,
  input  logic [RES_SIZE-1:0]  alu_res_i
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [WORD_W-1:0]     a_q, a_d;
  logic [WORD_W-1:0]     b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_SIZE-1:0]  lo_q, lo_d;
  logic                  rdy_q, rdy_d;
  logic                  valid_q, valid_d;
  logic [WORD_W-1:0]     data_q, data_d;
  logic                  c_q, c_d;
  logic                  z_q, z_d;
  logic                  we_q, we_d;
  logic [2:0]            alu_op_q, alu_op_d;
  logic                  ext_q, ext_d;
  logic                  misc_q, misc_d;
  logic [DATA_SIZE-1:0]  src_q, src_d;
  logic [DATA_SIZE-1:0]  dest_q, dest_d;

  logic                  accept;
  logic [WORD_W-1:0]     req_b_eff;
  logic [WORD_W-1:0]     result_full;
  logic                  unused_res;

  assign unused_res = ^alu_res_i[RES_SIZE-1:DATA_SIZE+1];

  // In DONE the back-to-back build forwards resp_ready so both handshakes can share an edge.
`ifdef ALU_SEQ16_B2B_EN
  assign req_ready_o = rdy_q | ((state_q == S_DONE) & resp_ready_i);
`else
  assign req_ready_o = rdy_q;
`endif

  assign accept      = req_valid_i & req_ready_o;
  assign req_b_eff   = req_op_i[1] ? WORD_W'(1) : req_b_i;
  assign result_full = {alu_res_i[DATA_SIZE-1:0], lo_q};

  // Next-state and registered-output logic; alu drive values are prepared one edge ahead.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    lo_d     = lo_q;
    rdy_d    = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    c_d      = c_q;
    z_d      = z_q;
    we_d     = we_q;
    alu_op_d = 3'b000;
    ext_d    = 1'b0;
    misc_d   = 1'b0;
    src_d    = '0;
    dest_d   = '0;

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          rdy_d = 1'b0;
        end
      end
      S_LO: begin
        lo_d     = alu_res_i[DATA_SIZE-1:0];
        misc_d   = alu_res_i[DATA_SIZE];
        alu_op_d = alu_op_q;
        ext_d    = 1'b1;
        dest_d   = a_q[WORD_W-1:DATA_SIZE];
        src_d    = b_q[WORD_W-1:DATA_SIZE];
        state_d  = S_HI;
      end
      S_HI: begin
        data_d  = result_full;
        c_d     = alu_res_i[DATA_SIZE];
        z_d     = (result_full == '0);
        we_d    = ~op_q[1];
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready_i) begin
          valid_d = 1'b0;
          rdy_d   = ~accept;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request can be taken in IDLE, or in DONE for the back-to-back build.
    if (accept) begin
      a_d      = req_a_i;
      b_d      = req_b_eff;
      op_d     = req_op_i;
      alu_op_d = req_op_i[0] ? ALU_SUB : ALU_ADD;
      dest_d   = req_a_i[DATA_SIZE-1:0];
      src_d    = req_b_eff[DATA_SIZE-1:0];
      ext_d    = 1'b0;
      misc_d   = 1'b0;
      state_d  = S_LO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      lo_q     <= '0;
      rdy_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      we_q     <= 1'b0;
      alu_op_q <= 3'b000;
      ext_q    <= 1'b0;
      misc_q   <= 1'b0;
      src_q    <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      lo_q     <= lo_d;
      rdy_q    <= rdy_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      c_q      <= c_d;
      z_q      <= z_d;
      we_q     <= we_d;
      alu_op_q <= alu_op_d;
      ext_q    <= ext_d;
      misc_q   <= misc_d;
      src_q    <= src_d;
      dest_q   <= dest_d;
    end
  end

  assign resp_valid_o    = valid_q;
  assign resp_data_o     = data_q;
  assign resp_c_o        = c_q;
  assign resp_z_o        = z_q;
  assign resp_flags_we_o = we_q;
  assign alu_op_o        = alu_op_q;
  assign alu_ext_o       = ext_q;
  assign alu_misc_o      = misc_q;
  assign alu_src_o       = src_q;
  assign alu_dest_o      = dest_q;

endmodule
